// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename/free-list types: tag, checkpoint column and wrap-bit pointer widths.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PHYS_REGS       = 64;
  localparam int unsigned NUM_ARCH_REGS       = 32;
  localparam int unsigned PHYS_REG_WIDTH      = 6;
  localparam int unsigned FREE_LIST_DEPTH     = 64;
  localparam int unsigned LOG_FREE_LIST_DEPTH = 6;
  localparam int unsigned CHECKPOINT_COLUMNS  = 4;
  localparam int unsigned INIT_FREE_REGS      = NUM_PHYS_REGS - NUM_ARCH_REGS;

  typedef logic [PHYS_REG_WIDTH-1:0]               phys_reg_tag_t;
  typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0]   checkpoint_column_t;
  typedef logic [LOG_FREE_LIST_DEPTH:0]            free_list_ptr_t;

  function automatic logic [LOG_FREE_LIST_DEPTH-1:0] ptr_index(input free_list_ptr_t ptr);
    return ptr[LOG_FREE_LIST_DEPTH-1:0];
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Dispatch/ROB/branch-unit side of the physical register free list.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic               dequeue_valid;
  logic               dequeue_ready;
  phys_reg_tag_t      dequeue_tag;
  logic               enqueue_valid;
  phys_reg_tag_t      enqueue_tag;
  logic               save_valid;
  checkpoint_column_t save_column;
  logic               restore_valid;
  checkpoint_column_t restore_column;
  free_list_ptr_t     free_count;
  logic               overflow_error;

  modport master (
    output dequeue_ready, enqueue_valid, enqueue_tag,
           save_valid, save_column, restore_valid, restore_column,
    input  dequeue_valid, dequeue_tag, free_count, overflow_error
  );

  modport slave (
    input  dequeue_ready, enqueue_valid, enqueue_tag,
           save_valid, save_column, restore_valid, restore_column,
    output dequeue_valid, dequeue_tag, free_count, overflow_error
  );
endinterface

// File: rtl/phys_reg_free_list_checkpoint_array.sv
// Bank of saved free-list pointers: one synchronous write port, one async read port.
module free_list_checkpoint_array
  import phys_reg_free_list_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  checkpoint_column_t i_wr_col,
  input  free_list_ptr_t     i_wr_ptr,
  input  checkpoint_column_t i_rd_col,
  output free_list_ptr_t     o_rd_ptr
);

  free_list_ptr_t r_col [CHECKPOINT_COLUMNS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '{default: '0};
    end else if (i_wr_en) begin
      r_col[i_wr_col] <= i_wr_ptr;
    end
  end

  assign o_rd_ptr = r_col[i_rd_col];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with checkpointed head pointer.
// Optional same-cycle enqueue-to-dequeue bypass when empty: FREE_LIST_BYPASS_EN.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  phys_reg_free_list_if.slave fl
);

  phys_reg_tag_t  r_entry [FREE_LIST_DEPTH];
  free_list_ptr_t r_head;
  free_list_ptr_t r_tail;
  logic           r_overflow;

  free_list_ptr_t w_count;
  free_list_ptr_t w_head_next;
  free_list_ptr_t w_restore_ptr;
  logic           w_empty;
  logic           w_full;
  logic           w_bypass;
  logic           w_pop;
  logic           w_push;
  logic           w_save;

  always_comb begin
    w_count = r_tail - r_head;
    w_empty = (r_head == r_tail);
    w_full  = (w_count == free_list_ptr_t'(FREE_LIST_DEPTH));
`ifdef FREE_LIST_BYPASS_EN
    w_bypass = w_empty && fl.enqueue_valid && !fl.restore_valid;
`else
    w_bypass = 1'b0;
`endif
    // Restore owns the head this cycle, so it suppresses both pop and save.
    w_pop       = !w_empty && fl.dequeue_ready && !fl.restore_valid;
    w_push      = fl.enqueue_valid && !w_full && !(w_bypass && fl.dequeue_ready);
    w_save      = fl.save_valid && !fl.restore_valid;
    w_head_next = fl.restore_valid ? w_restore_ptr : (r_head + free_list_ptr_t'(w_pop));
  end

  assign fl.dequeue_valid  = !w_empty || w_bypass;
  assign fl.dequeue_tag    = w_bypass ? fl.enqueue_tag : r_entry[ptr_index(r_head)];
  assign fl.free_count     = w_count;
  assign fl.overflow_error = r_overflow;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
        r_entry[i[LOG_FREE_LIST_DEPTH-1:0]] <=
          (i < INIT_FREE_REGS) ? phys_reg_tag_t'(NUM_ARCH_REGS + i) : '0;
      end
      r_head     <= '0;
      r_tail     <= free_list_ptr_t'(INIT_FREE_REGS);
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_entry[ptr_index(r_tail)] <= fl.enqueue_tag;
      end
      r_tail <= r_tail + free_list_ptr_t'(w_push);
      r_head <= w_head_next;
      if (fl.enqueue_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  free_list_checkpoint_array u_ckpt (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_wr_en  (w_save),
    .i_wr_col (fl.save_column),
    .i_wr_ptr (w_head_next),
    .i_rd_col (fl.restore_column),
    .o_rd_ptr (w_restore_ptr)
  );

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: expected free tags queued on enqueue/reset, popped on dequeue.
module tb_phys_reg_free_list;

  typedef logic [5:0] tag_q_t [$];

  logic CLK;
  logic RST;
  phys_reg_free_list_if fl_if ();

  phys_reg_free_list dut (
    .CLK (CLK),
    .RST (RST),
    .fl  (fl_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  tag_q_t exp_q;
  tag_q_t ckpt_q [4];
  bit     exp_ovf;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit deq, input bit enq, input logic [5:0] etag,
                       input bit sv, input logic [1:0] scol, input bit rs, input logic [1:0] rcol);
    fl_if.dequeue_ready  = deq;
    fl_if.enqueue_valid  = enq;
    fl_if.enqueue_tag    = etag;
    fl_if.save_valid     = sv;
    fl_if.save_column    = scol;
    fl_if.restore_valid  = rs;
    fl_if.restore_column = rcol;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 32; i < 64; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 4; c++) ckpt_q[c] = exp_q;
    exp_ovf = 1'b0;
  endtask

  // Reset is asserted together with junk requests that must be discarded.
  task automatic do_reset();
    RST = 1'b1;
    drive(1'b1, 1'b1, 6'd3, 1'b1, 2'd1, 1'b1, 2'd2);
    @(posedge CLK); #1;
    RST = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    model_reset();
  endtask

  task automatic step(input bit deq, input bit enq, input logic [5:0] etag,
                      input bit sv, input logic [1:0] scol, input bit rs, input logic [1:0] rcol);
    bit empty, bypass, exp_valid, was_full;
    drive(deq, enq, etag, sv, scol, rs, rcol);
    #2;
    empty = (exp_q.size() == 0);
`ifdef FREE_LIST_BYPASS_EN
    bypass = empty && enq && !rs;
`else
    bypass = 1'b0;
`endif
    exp_valid = !empty || bypass;
    was_full  = (exp_q.size() == 64);
    check_eq("dequeue_valid", fl_if.dequeue_valid, exp_valid);
    if (exp_valid)
      check_eq("dequeue_tag", fl_if.dequeue_tag, bypass ? etag : exp_q[0]);
    check_eq("free_count", fl_if.free_count, exp_q.size());
    check_eq("overflow_error", fl_if.overflow_error, exp_ovf);

    if (rs) begin
      exp_q = ckpt_q[rcol];
    end else begin
      if (deq && exp_valid && !bypass) void'(exp_q.pop_front());
      if (sv) ckpt_q[scol] = exp_q;
    end
    if (enq && !(bypass && deq)) begin
      if (was_full) exp_ovf = 1'b1;
      else begin
        exp_q.push_back(etag);
        for (int c = 0; c < 4; c++) ckpt_q[c].push_back(etag);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic deq_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(posedge CLK); #1;

    // Reset state then full drain, plus a ready while empty.
    do_reset();
    idle();
    deq_n(32);
    idle();
    deq_n(1);
    idle();

    // Save with no dequeue, consume five, rewind.
    do_reset();
    step(1'b0, 1'b0, 6'd0, 1'b1, 2'd2, 1'b0, 2'd0);
    deq_n(5);
    step(1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    idle();

    // Save in the same cycle as a dequeue captures the advanced head.
    do_reset();
    step(1'b1, 1'b0, 6'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    deq_n(3);
    step(1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    idle();

    // Empty list: enqueue 7 and 9, then the pass-through case.
    do_reset();
    deq_n(32);
    step(1'b0, 1'b1, 6'd7, 1'b0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 6'd9, 1'b0, 2'd0, 1'b0, 2'd0);
    deq_n(2);
    idle();
    step(1'b1, 1'b1, 6'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    idle();
    deq_n(1);
    idle();

    // Wrap-around with simultaneous enqueue and dequeue.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 6'(i), 1'b0, 2'd0, 1'b0, 2'd0);
    deq_n(32);
    idle();

    // Restore alongside enqueue and a ready that must be ignored.
    do_reset();
    deq_n(4);
    step(1'b0, 1'b0, 6'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    deq_n(2);
    step(1'b1, 1'b1, 6'd12, 1'b0, 2'd0, 1'b1, 2'd3);
    idle();
    deq_n(2);

    // Fill to 64 then overflow; sticky until reset.
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 6'(i), 1'b0, 2'd0, 1'b0, 2'd0);
    idle();
    deq_n(3);
    idle();
    do_reset();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
